// File: rtl/rdyack_pkg.sv
// Shared defaults, LFSR tap mask and FSM state type for the rdy/ack responder.
// The responder's optional sequence checker is enabled by RDYACK_RESP_SEQCHK_EN.
package rdyack_pkg;

  localparam int          DW_DEFAULT   = 11;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rdyack_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that drives the responder's backpressure.
// Advances every cycle out of reset, independent of traffic.
module rdyack_lfsr
  import rdyack_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
    end else begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/rdyack_responder.sv
// Rdy/ack sink with pseudo-random backpressure, word count/sum and protocol checking.
// Define RDYACK_RESP_SEQCHK_EN to add the incrementing-sequence checker and its mism output.
module rdyack_responder
  import rdyack_pkg::*;
#(
  parameter int          DW   = DW_DEFAULT,
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rdy,
  output logic          i_ack,
  input  logic [DW-1:0] i_dat,
  input  logic [2:0]    stall_thr,
  output logic [15:0]   cnt,
  output logic [15:0]   sum,
`ifdef RDYACK_RESP_SEQCHK_EN
  output logic          mism,
`endif
  output logic          perr
);

  logic [15:0]   lfsr_state;
  logic [2:0]    lfsr_nlow;
  logic          canack_q, canack_d;
  logic          xfer;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   sum_q, sum_d;
  state_e        state_q, state_d;
  logic [DW-1:0] cap_q, cap_d;
  logic          perr_q, perr_d;

  rdyack_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr_state)
  );

  // canack is judged against the LFSR value that loads on the same edge.
  assign lfsr_nlow = {lfsr_state[1:0], ^(lfsr_state & LFSR_TAPS)};
  assign canack_d  = (lfsr_nlow >= stall_thr);
  assign xfer      = i_rdy && canack_q;
  assign i_ack     = xfer;

  assign cnt_d = xfer ? cnt_q + 16'd1 : cnt_q;
  assign sum_d = xfer ? sum_q + 16'(i_dat) : sum_q;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (i_rdy && !canack_q) begin
          state_d = PEND;
          cap_d   = i_dat;
        end
      end
      PEND: begin
        if (!i_rdy || (i_dat != cap_q)) begin
          perr_d = 1'b1;
        end
        if (!i_rdy || xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      canack_q <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      state_q  <= IDLE;
      cap_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      canack_q <= canack_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      state_q  <= state_d;
      cap_q    <= cap_d;
      perr_q   <= perr_d;
    end
  end

  assign cnt  = cnt_q;
  assign sum  = sum_q;
  assign perr = perr_q;

`ifdef RDYACK_RESP_SEQCHK_EN
  logic [DW-1:0] exp_q, exp_d;
  logic          mism_q, mism_d;

  // Each accepted word must be one more than the previous; first expected is 0.
  always_comb begin
    exp_d  = exp_q;
    mism_d = mism_q;
    if (xfer) begin
      if (i_dat != exp_q) begin
        mism_d = 1'b1;
      end
      exp_d = i_dat + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q  <= '0;
      mism_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      mism_q <= mism_d;
    end
  end

  assign mism = mism_q;
`endif

endmodule

// File: tb/tb_rdyack_responder.sv
// Self-checking bench for rdyack_responder: directed scenarios plus randomized traffic
// compared against a rule-level reference model (RDYACK_RESP_SEQCHK_EN adds mism checks).
module tb_rdyack_responder;

  localparam int DW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_rdy = 1'b0;
  logic          i_ack;
  logic [DW-1:0] i_dat = '0;
  logic [2:0]    stall_thr = 3'd0;
  logic [15:0]   cnt;
  logic [15:0]   sum;
  logic          perr;
`ifdef RDYACK_RESP_SEQCHK_EN
  logic          mism;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  int mLfsr, mCnt, mSum, mXfers, mHeld, mExp;
  bit mCan, mPerr, mPend, mMism;

  rdyack_responder dut (
    .clk       (clk),
    .rst       (rst),
    .i_rdy     (i_rdy),
    .i_ack     (i_ack),
    .i_dat     (i_dat),
    .stall_thr (stall_thr),
    .cnt       (cnt),
    .sum       (sum),
`ifdef RDYACK_RESP_SEQCHK_EN
    .mism      (mism),
`endif
    .perr      (perr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mLfsr  = 16'hACE1;
    mCan   = 1'b0;
    mCnt   = 0;
    mSum   = 0;
    mXfers = 0;
    mPerr  = 1'b0;
    mPend  = 1'b0;
    mHeld  = 0;
    mExp   = 0;
    mMism  = 1'b0;
  endtask

  task automatic checkState();
    checkOutput("cnt", 32'(cnt), 32'(mCnt));
    checkOutput("sum", 32'(sum), 32'(mSum));
    checkOutput("perr", 32'(perr), 32'(mPerr));
`ifdef RDYACK_RESP_SEQCHK_EN
    checkOutput("mism", 32'(mism), 32'(mMism));
`endif
  endtask

  // Reset asserted away from the clock edge, released on a falling edge.
  task automatic doReset();
    rst   = 1'b0;
    i_rdy = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_ack", 32'(i_ack), 32'd0);
    checkState();
    @(negedge clk);
    rst   = 1'b1;
    i_rdy = 1'b0;
  endtask

  // One clock of traffic: drive, check ack, clock, then check registered outputs.
  task automatic applyStimulus(input bit rdy, input int datIn, input int thr);
    bit ack;
    int dat, fb;
    dat = datIn & 2047;
    i_rdy     = rdy;
    i_dat     = dat[DW-1:0];
    stall_thr = thr[2:0];
    #1;
    ack = rdy && mCan;
    checkOutput("i_ack", 32'(i_ack), 32'(ack));
    @(posedge clk);
    if (mPend) begin
      if (!rdy || dat != mHeld) mPerr = 1'b1;
      if (!rdy || ack) mPend = 1'b0;
    end else if (rdy && !ack) begin
      mPend = 1'b1;
      mHeld = dat;
    end
    if (ack) begin
      mCnt = (mCnt + 1) % 65536;
      mSum = (mSum + dat) % 65536;
      mXfers++;
      if (dat != mExp) mMism = 1'b1;
      mExp = (dat + 1) % 2048;
    end
    fb    = ((mLfsr >> 15) ^ (mLfsr >> 13) ^ (mLfsr >> 12) ^ (mLfsr >> 10)) & 1;
    mLfsr = ((mLfsr << 1) | fb) & 16'hFFFF;
    mCan  = (mLfsr % 8) >= thr;
    #1;
    checkState();
  endtask

  initial begin
    int r, d;
    bit rdy;

    // Power-on reset
    doReset();

    // Back-to-back: 8 words in 8 cycles with no backpressure
    applyStimulus(1'b0, 0, 0);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, i, 0);
    checkOutput("b2b_cnt", 32'(cnt), 32'd8);
    checkOutput("b2b_sum", 32'(sum), 32'd36);
    checkOutput("b2b_perr", 32'(perr), 32'd0);

    // Heavy backpressure with stable data holds no violation
    doReset();
    for (int i = 0; i < 60; i++) applyStimulus(1'b1, 'h5A5, 7);
    checkOutput("stall_perr", 32'(perr), 32'd0);

    // Dropping rdy while pending is a violation and it sticks
    doReset();
    applyStimulus(1'b1, 5, 7);
    applyStimulus(1'b0, 5, 7);
    checkOutput("drop_perr", 32'(perr), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0);
    checkOutput("drop_sticky", 32'(perr), 32'd1);

    // Changing data while pending is a violation
    doReset();
    applyStimulus(1'b1, 1, 7);
    applyStimulus(1'b1, 2, 7);
    checkOutput("chg_perr", 32'(perr), 32'd1);

`ifdef RDYACK_RESP_SEQCHK_EN
    // Sequence checker: 0,1,2 fine, then 4 breaks the sequence
    doReset();
    applyStimulus(1'b0, 0, 0);
    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b1, 1, 0);
    applyStimulus(1'b1, 2, 0);
    checkOutput("seq_ok", 32'(mism), 32'd0);
    applyStimulus(1'b1, 4, 0);
    checkOutput("seq_bad", 32'(mism), 32'd1);
    doReset();
    checkOutput("seq_rst", 32'(mism), 32'd0);
`endif

    // Randomized traffic, mostly protocol-compliant, with occasional resets
    doReset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        doReset();
      end else begin
        if (i % 100 == 0) stall_thr = 3'($urandom_range(0, 7));
        if (mPend && $urandom_range(0, 19) != 0) begin
          rdy = 1'b1;
          d   = mHeld;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
          d   = $urandom_range(0, 2047);
        end
        applyStimulus(rdy, d, int'(stall_thr));
      end
    end

    // Counter and sum wrap after 65537 single-valued transfers
    doReset();
    applyStimulus(1'b0, 0, 0);
    while (mXfers < 65537) applyStimulus(1'b1, 1, 0);
    checkOutput("wrap_cnt", 32'(cnt), 32'd1);
    checkOutput("wrap_sum", 32'(sum), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
